mcu0_seq: RTL and testbench

- Multi-cycle control sequencer for the mcu0 accumulator datapath (PC, IR, A, SW, ALU, shared byte-addressed 16-bit memory).
- Replaces the single-cycle combinational control unit.
- Time-multiplexes the one memory port between instruction fetch and LD/ST data access, using a ready handshake so the memory may insert wait states.
- Sequences per-instruction register write enables, counts retired instructions, and halts on illegal opcodes or a memory timeout.

---
 rtl/mcu0_pkg.sv | 38 +++
 rtl/mcu0_seq_decode.sv | 84 ++++++++
 rtl/mcu0_seq.sv | 186 ++++++++++++++++++
 tb/tb_mcu0_seq.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mcu0_pkg.sv
// mcu0 shared constants: opcodes, ALU ops, sequencer states, halt causes.
// Used by the sequencer, datapath and ALU.
package mcu0_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_MEM    = 3'd3,
    ST_EXEC   = 3'd4,
    ST_HALT   = 3'd7
  } state_e;

  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_JMP = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_CMP = 4'h4;
  localparam logic [3:0] OP_JEQ = 4'h5;

  localparam logic [3:0] ALU_ZERO  = 4'h0;
  localparam logic [3:0] ALU_ADD   = 4'h1;
  localparam logic [3:0] ALU_CMP   = 4'hE;
  localparam logic [3:0] ALU_APASS = 4'hF;

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_ILLEGAL = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  function automatic logic op_legal(input logic [3:0] op);
    return op <= OP_JEQ;
  endfunction

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op == OP_LD) || (op == OP_ST) || (op == OP_ADD);
  endfunction

endpackage

// File: rtl/mcu0_seq_decode.sv
// mcu0 sequencer strobe decode: Mealy outputs from state, op,
// mem_ready and z. go gates the fetch request (single-step hold).
module mcu0_seq_decode
  import mcu0_pkg::*;
(
  input  logic [2:0] state,
  input  logic [3:0] op,
  input  logic       mem_ready,
  input  logic       z,
  input  logic       go,
  output logic       mem_req,
  output logic       addr_sel,
  output logic       mw,
  output logic       irw,
  output logic       pcw,
  output logic       pcmux,
  output logic       aw,
  output logic       sww,
  output logic [3:0] aluop
);

  // Per-state strobe generation; idle/decode/halt leave all defaults.
  always_comb begin
    mem_req  = 1'b0;
    addr_sel = 1'b0;
    mw       = 1'b0;
    irw      = 1'b0;
    pcw      = 1'b0;
    pcmux    = 1'b0;
    aw       = 1'b0;
    sww      = 1'b0;
    aluop    = ALU_ZERO;
    unique case (1'b1)
      (state == ST_FETCH): begin
        if (go) begin
          mem_req = 1'b1;
          if (mem_ready) begin
            irw = 1'b1;
            pcw = 1'b1;
          end
        end
      end
      (state == ST_MEM): begin
        mem_req  = 1'b1;
        addr_sel = 1'b1;
        if (mem_ready) begin
          unique case (1'b1)
            (op == OP_LD): begin
              aw    = 1'b1;
              aluop = ALU_APASS;
            end
            (op == OP_ADD): begin
              aw    = 1'b1;
              aluop = ALU_ADD;
            end
            (op == OP_ST): mw = 1'b1;
            default: ;
          endcase
        end
      end
      (state == ST_EXEC): begin
        unique case (1'b1)
          (op == OP_CMP): begin
            mem_req  = 1'b1;
            addr_sel = 1'b1;
            aluop    = ALU_CMP;
            sww      = mem_ready;
          end
          (op == OP_JMP): begin
            pcw   = 1'b1;
            pcmux = 1'b1;
          end
          (op == OP_JEQ): begin
            pcw   = z;
            pcmux = 1'b1;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mcu0_seq.sv
// mcu0 multi-cycle control sequencer (fetch/decode/mem/exec/halt).
// Optional single-step gate: define MCU0_SEQ_STEP_EN.
module mcu0_seq
  import mcu0_pkg::*;
#(
  parameter int CNT_W   = 16,
  parameter int TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [3:0]       op,
  input  logic             z,
  input  logic             mem_ready,
`ifdef MCU0_SEQ_STEP_EN
  input  logic             step,
  output logic             step_wait,
`endif
  output logic             mem_req,
  output logic             addr_sel,
  output logic             mw,
  output logic             irw,
  output logic             pcw,
  output logic             pcmux,
  output logic             aw,
  output logic             sww,
  output logic [3:0]       aluop,
  output logic [2:0]       state,
  output logic             halted,
  output logic [1:0]       err,
  output logic [CNT_W-1:0] icount
);

  localparam int WC_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(TIMEOUT);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] icount_q, icount_d;
  logic [1:0]       err_q, err_d;
  logic             halted_q, halted_d;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic             go;
  logic             access;
  logic             tmo;

  logic d_mem_req, d_addr_sel, d_mw, d_irw;
  logic d_pcw, d_pcmux, d_aw, d_sww;
  logic [3:0] d_aluop;

`ifdef MCU0_SEQ_STEP_EN
  logic step_prev_q, step_prev_d;
  logic pend_q, pend_d;
  logic step_open;

  assign step_open = (state_q == ST_IDLE) || (state_q == ST_FETCH);
  assign go        = pend_q;
  assign step_wait = step_open && !pend_q;

  // One registered pulse releases exactly one fetch.
  always_comb begin
    step_prev_d = step;
    pend_d      = pend_q;
    if ((state_q == ST_FETCH) && pend_q && mem_ready) begin
      pend_d = 1'b0;
    end
    if (step_open && step && !step_prev_q) begin
      pend_d = 1'b1;
    end
  end

  // Step edge detect and pending-pulse registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step_prev_q <= 1'b0;
      pend_q      <= 1'b0;
    end else begin
      step_prev_q <= step_prev_d;
      pend_q      <= pend_d;
    end
  end
`else
  assign go = 1'b1;
`endif

  mcu0_seq_decode u_dec (
    .state     (state_q),
    .op        (op),
    .mem_ready (mem_ready),
    .z         (z),
    .go        (go),
    .mem_req   (d_mem_req),
    .addr_sel  (d_addr_sel),
    .mw        (d_mw),
    .irw       (d_irw),
    .pcw       (d_pcw),
    .pcmux     (d_pcmux),
    .aw        (d_aw),
    .sww       (d_sww),
    .aluop     (d_aluop)
  );

  assign mem_req  = d_mem_req & ~reset;
  assign addr_sel = d_addr_sel;
  assign mw       = d_mw & ~reset;
  assign irw      = d_irw & ~reset;
  assign pcw      = d_pcw & ~reset;
  assign pcmux    = d_pcmux;
  assign aw       = d_aw & ~reset;
  assign sww      = d_sww & ~reset;
  assign aluop    = d_aluop;
  assign state    = state_q;
  assign halted   = halted_q;
  assign err      = err_q;
  assign icount   = icount_q;

  assign access = ((state_q == ST_FETCH) && go)
               || (state_q == ST_MEM)
               || ((state_q == ST_EXEC) && (op == OP_CMP));
  assign tmo = (TIMEOUT != 0) && access && !mem_ready
            && (wcnt_q == WC_MAX);

  // Next state, retire count, wait counter and halt cause.
  always_comb begin
    state_d  = state_q;
    icount_d = icount_q;
    err_d    = err_q;
    halted_d = halted_q;
    wcnt_d   = '0;
    if ((TIMEOUT != 0) && access && !mem_ready) begin
      wcnt_d = wcnt_q + 1'b1;
    end
    case (state_q)
      ST_IDLE: state_d = ST_FETCH;
      ST_FETCH: begin
        if (go && mem_ready) state_d = ST_DECODE;
      end
      ST_DECODE: begin
        if (!op_legal(op)) begin
          state_d  = ST_HALT;
          err_d    = ERR_ILLEGAL;
          halted_d = 1'b1;
        end else if (op_is_mem(op)) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_EXEC;
        end
      end
      ST_MEM: begin
        if (mem_ready) begin
          state_d  = ST_FETCH;
          icount_d = icount_q + 1'b1;
        end
      end
      ST_EXEC: begin
        if ((op != OP_CMP) || mem_ready) begin
          state_d  = ST_FETCH;
          icount_d = icount_q + 1'b1;
        end
      end
      ST_HALT: ;
      default: state_d = ST_HALT;
    endcase
    if (tmo) begin
      state_d  = ST_HALT;
      err_d    = ERR_TIMEOUT;
      halted_d = 1'b1;
    end
  end

  // Sequencer state registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      icount_q <= '0;
      err_q    <= ERR_NONE;
      halted_q <= 1'b0;
      wcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      icount_q <= icount_d;
      err_q    <= err_d;
      halted_q <= halted_d;
      wcnt_q   <= wcnt_d;
    end
  end

endmodule

// File: tb/tb_mcu0_seq.sv
// Directed bench for mcu0_seq with a small accumulator datapath
// and word memory model driven by the sequencer strobes.
module tb_mcu0_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        mem_ready = 1'b0;
  logic        mem_req, addr_sel, mw, irw, pcw, pcmux, aw, sww;
  logic [3:0]  aluop;
  logic [2:0]  state;
  logic        halted;
  logic [1:0]  err;
  logic [15:0] icount;
`ifdef MCU0_SEQ_STEP_EN
  logic        step = 1'b0;
  logic        step_wait;
`endif

  logic [15:0] mem [0:2047];
  logic [15:0] pc, ir, acc, sw;
  logic [15:0] dp_addr, rdata;
  logic        z;

  int checks = 0;
  int errors = 0;
  int mw_cnt = 0, aw_cnt = 0, irw_cnt = 0, st_cnt = 0;
  logic [15:0] st_addr = '0, st_data = '0;
  int mw_base, aw_base, irw_base, st_base;

  always #5 clock = ~clock;

  mcu0_seq dut (
    .clock     (clock),
    .reset     (reset),
    .op        (ir[15:12]),
    .z         (z),
    .mem_ready (mem_ready),
`ifdef MCU0_SEQ_STEP_EN
    .step      (step),
    .step_wait (step_wait),
`endif
    .mem_req   (mem_req),
    .addr_sel  (addr_sel),
    .mw        (mw),
    .irw       (irw),
    .pcw       (pcw),
    .pcmux     (pcmux),
    .aw        (aw),
    .sww       (sww),
    .aluop     (aluop),
    .state     (state),
    .halted    (halted),
    .err       (err),
    .icount    (icount)
  );

  assign z       = sw[14];
  assign dp_addr = {4'h0, (addr_sel ? ir[11:0] : pc[11:0])};
  assign rdata   = mem[dp_addr[11:1]];

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      pc  <= '0;
      ir  <= '0;
      acc <= '0;
      sw  <= '0;
    end else begin
      if (irw) ir <= rdata;
      if (pcw) pc <= pcmux ? {4'h0, ir[11:0]} : pc + 16'd2;
      if (aw) acc <= (aluop == 4'hF) ? rdata : acc + rdata;
      if (sww) sw[14] <= (acc == rdata);
    end
  end

  always @(posedge clock) begin
    if (mw) begin
      mw_cnt  <= mw_cnt + 1;
      st_cnt  <= st_cnt + 1;
      st_addr <= dp_addr;
      st_data <= acc;
    end
    if (aw) aw_cnt <= aw_cnt + 1;
    if (irw) irw_cnt <= irw_cnt + 1;
  end

  task automatic clear_mem;
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0;
  endtask

  task automatic do_reset;
    @(negedge clock);
    reset = 1'b1;
    mem_ready = 1'b0;
    @(negedge clock);
    mw_base = mw_cnt;
    aw_base = aw_cnt;
    irw_base = irw_cnt;
    st_base = st_cnt;
    reset = 1'b0;
  endtask

  task automatic cyc(input logic rdy);
    @(negedge clock);
    mem_ready = rdy;
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++; if (state !== 3'd0) begin errors++; $display("FAIL reset_state got %0d exp 0", state); end
    checks++; if (icount !== 16'd0) begin errors++; $display("FAIL reset_icount got %0d exp 0", icount); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted got %0b exp 0", halted); end
    checks++; if (err !== 2'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err); end
    checks++; if ({mem_req, mw, irw, pcw, aw, sww} !== 6'b0) begin
      errors++; $display("FAIL reset_strobes got %b exp 000000", {mem_req, mw, irw, pcw, aw, sww});
    end
  endtask

  task automatic test_ld_add_st;
    logic [2:0] seq [9] = '{3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3, 3'd1, 3'd2, 3'd3};
    clear_mem;
    mem[0] = 16'h0100; mem[1] = 16'h1102; mem[2] = 16'h3104;
    mem[16'h80] = 16'd3; mem[16'h81] = 16'd4;
    do_reset;
    for (int i = 0; i < 9; i++) begin
      cyc(1'b1);
      checks++; if (state !== seq[i]) begin errors++; $display("FAIL las_state[%0d] got %0d exp %0d", i, state, seq[i]); end
    end
    checks++; if (icount !== 16'd2) begin errors++; $display("FAIL las_icount_pre got %0d exp 2", icount); end
    @(negedge clock); #1;
    checks++; if (icount !== 16'd3) begin errors++; $display("FAIL las_icount got %0d exp 3", icount); end
    checks++; if (acc !== 16'd7) begin errors++; $display("FAIL las_acc got %0d exp 7", acc); end
    checks++; if (st_cnt - st_base !== 1) begin errors++; $display("FAIL las_st_cnt got %0d exp 1", st_cnt - st_base); end
    checks++; if (st_addr !== 16'h0104) begin errors++; $display("FAIL las_st_addr got %0h exp 104", st_addr); end
    checks++; if (st_data !== 16'd7) begin errors++; $display("FAIL las_st_data got %0d exp 7", st_data); end
    checks++; if (mw_cnt - mw_base !== 1) begin errors++; $display("FAIL las_mw_cycles got %0d exp 1", mw_cnt - mw_base); end
  endtask

  task automatic test_cmp_jeq(input logic [15:0] ld_insn, input logic [15:0] exp_pc,
                              input logic exp_z);
    clear_mem;
    mem[0] = ld_insn; mem[1] = 16'h4100; mem[2] = 16'h5040;
    mem[16'h80] = 16'd5; mem[16'h81] = 16'd6;
    do_reset;
    repeat (9) cyc(1'b1);
    @(negedge clock); #1;
    checks++; if (pc !== exp_pc) begin errors++; $display("FAIL jeq_pc got %0h exp %0h", pc, exp_pc); end
    checks++; if (z !== exp_z) begin errors++; $display("FAIL jeq_z got %0b exp %0b", z, exp_z); end
    checks++; if (icount !== 16'd3) begin errors++; $display("FAIL jeq_icount got %0d exp 3", icount); end
  endtask

  task automatic test_fetch_wait;
    clear_mem;
    mem[0] = 16'h2010;
    do_reset;
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0);
      checks++; if ({state, mem_req, irw, pcw} !== {3'd1, 3'b100}) begin
        errors++; $display("FAIL fw_wait[%0d] got %b exp 001100", i, {state, mem_req, irw, pcw});
      end
    end
    cyc(1'b1);
    checks++; if ({state, irw, pcw, pcmux} !== {3'd1, 3'b110}) begin
      errors++; $display("FAIL fw_ready got %b exp 001110", {state, irw, pcw, pcmux});
    end
    cyc(1'b1);
    checks++; if (state !== 3'd2) begin errors++; $display("FAIL fw_decode got %0d exp 2", state); end
    cyc(1'b1);
    @(negedge clock); #1;
    checks++; if (pc !== 16'h0010) begin errors++; $display("FAIL fw_pc got %0h exp 10", pc); end
    checks++; if (icount !== 16'd1) begin errors++; $display("FAIL fw_icount got %0d exp 1", icount); end
    checks++; if (irw_cnt - irw_base !== 1) begin errors++; $display("FAIL fw_irw_cnt got %0d exp 1", irw_cnt - irw_base); end
  endtask

  task automatic test_timeout_edge;
    clear_mem;
    mem[0] = 16'h0100; mem[16'h80] = 16'h1234;
    do_reset;
    cyc(1'b1); cyc(1'b1);
    repeat (15) cyc(1'b0);
    cyc(1'b1);
    checks++; if ({state, aw} !== {3'd3, 1'b1}) begin errors++; $display("FAIL tedge_ready got %b exp 0111", {state, aw}); end
    @(negedge clock); #1;
    checks++; if (acc !== 16'h1234) begin errors++; $display("FAIL tedge_acc got %0h exp 1234", acc); end
    checks++; if ({halted, icount} !== {1'b0, 16'd1}) begin errors++; $display("FAIL tedge_retire got %0h exp 1", {halted, icount}); end
  endtask

  task automatic test_timeout_halt;
    clear_mem;
    mem[0] = 16'h0100; mem[16'h80] = 16'h1234;
    do_reset;
    cyc(1'b1); cyc(1'b1);
    repeat (16) cyc(1'b0);
    checks++; if ({state, halted} !== {3'd3, 1'b0}) begin errors++; $display("FAIL thalt_pre got %b exp 0110", {state, halted}); end
    @(negedge clock); #1;
    checks++; if (state !== 3'd7) begin errors++; $display("FAIL thalt_state got %0d exp 7", state); end
    checks++; if ({halted, err} !== 3'b110) begin errors++; $display("FAIL thalt_err got %b exp 110", {halted, err}); end
    checks++; if (aw_cnt - aw_base !== 0) begin errors++; $display("FAIL thalt_aw got %0d exp 0", aw_cnt - aw_base); end
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL thalt_req got %0b exp 0", mem_req); end
    checks++; if (icount !== 16'd0) begin errors++; $display("FAIL thalt_icount got %0d exp 0", icount); end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checks++; if ({state, err, halted} !== 6'b0) begin errors++; $display("FAIL thalt_reset got %b exp 000000", {state, err, halted}); end
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_illegal;
    clear_mem;
    mem[0] = 16'h9000;
    do_reset;
    cyc(1'b1);
    cyc(1'b1);
    checks++; if ({state, mem_req} !== {3'd2, 1'b0}) begin errors++; $display("FAIL ill_decode got %b exp 0100", {state, mem_req}); end
    @(negedge clock); #1;
    checks++; if ({state, halted, err} !== {3'd7, 1'b1, 2'd1}) begin
      errors++; $display("FAIL ill_halt got %b exp 111101", {state, halted, err});
    end
    checks++; if (icount !== 16'd0) begin errors++; $display("FAIL ill_icount got %0d exp 0", icount); end
    repeat (3) cyc(1'b1);
    checks++; if ({state, mem_req, irw} !== {3'd7, 2'b00}) begin errors++; $display("FAIL ill_hold got %b exp 11100", {state, mem_req, irw}); end
  endtask

  task automatic test_reset_mid_st;
    clear_mem;
    mem[0] = 16'h3104;
    do_reset;
    cyc(1'b1); cyc(1'b1);
    cyc(1'b0);
    checks++; if ({state, mem_req, mw} !== {3'd3, 2'b10}) begin errors++; $display("FAIL rst_st_mem got %b exp 01110", {state, mem_req, mw}); end
    cyc(1'b0);
    @(negedge clock);
    mem_ready = 1'b1;
    reset = 1'b1;
    #1;
    checks++; if ({mem_req, mw, state} !== 5'b0) begin errors++; $display("FAIL rst_st_drop got %b exp 00000", {mem_req, mw, state}); end
    @(negedge clock);
    reset = 1'b0;
    cyc(1'b1);
    checks++; if ({state, mem_req} !== {3'd1, 1'b1}) begin errors++; $display("FAIL rst_st_refetch got %b exp 0011", {state, mem_req}); end
    checks++; if (mw_cnt - mw_base !== 0) begin errors++; $display("FAIL rst_st_mw got %0d exp 0", mw_cnt - mw_base); end
  endtask

`ifdef MCU0_SEQ_STEP_EN
  task automatic test_step;
    clear_mem;
    mem[0] = 16'h0100; mem[1] = 16'h1102;
    mem[16'h80] = 16'd3; mem[16'h81] = 16'd4;
    step = 1'b0;
    do_reset;
    repeat (10) cyc(1'b1);
    checks++; if ({state, step_wait, mem_req} !== {3'd1, 2'b10}) begin
      errors++; $display("FAIL step_block got %b exp 00110", {state, step_wait, mem_req});
    end
    checks++; if (icount !== 16'd0) begin errors++; $display("FAIL step_icount0 got %0d exp 0", icount); end
    for (int p = 1; p <= 2; p++) begin
      @(negedge clock); step = 1'b1;
      @(negedge clock); step = 1'b0;
      repeat (10) cyc(1'b1);
      checks++; if (icount !== 16'(p)) begin errors++; $display("FAIL step_icount got %0d exp %0d", icount, p); end
      checks++; if (step_wait !== 1'b1) begin errors++; $display("FAIL step_wait got %0b exp 1", step_wait); end
    end
    checks++; if (acc !== 16'd7) begin errors++; $display("FAIL step_acc got %0d exp 7", acc); end
  endtask
`endif

  initial begin
    clear_mem;
    test_reset;
`ifdef MCU0_SEQ_STEP_EN
    test_step;
`else
    test_ld_add_st;
    test_cmp_jeq(16'h0100, 16'h0040, 1'b1);
    test_cmp_jeq(16'h0102, 16'h0006, 1'b0);
    test_fetch_wait;
    test_timeout_edge;
    test_timeout_halt;
    test_illegal;
    test_reset_mid_st;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
